// File: rtl/reg_test_pkg.sv
// =============================================================================
// Package     : reg_test_pkg
// Description : Shared vector table, FSM state type and limits for the
//               register stimulus/check engine.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package reg_test_pkg;

    localparam int NUM_VEC     = 4;
    localparam int IDXW        = 2;
    localparam int LATENCY_MAX = 8;

    localparam logic [7:0] REG_TEST_VEC [0:NUM_VEC-1] = '{8'h05, 8'h0A, 8'h03, 8'h00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } reg_chk_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_stim_checker_if.sv
// =============================================================================
// Interface   : reg_stim_checker_if
// Description : Run control, stimulus/response and result bundle of the
//               register stimulus/check engine.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface reg_stim_checker_if
    import reg_test_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERRW  = 8
);
    logic             start;
    logic [WIDTH-1:0] stim;
    logic [WIDTH-1:0] resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERRW-1:0]  err_count;
    logic [IDXW-1:0]  first_fail_idx;

    // master: the checker engine; slave: the controller/DUT side
    modport master (
        input  start, resp,
        output stim, busy, done, pass, err_count, first_fail_idx
    );

    modport slave (
        output start, resp,
        input  stim, busy, done, pass, err_count, first_fail_idx
    );
endinterface

`default_nettype wire

// File: rtl/reg_delay_line.sv
// =============================================================================
// Module      : reg_delay_line
// Description : DEPTH-stage shift register of {valid, value, idx} records.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module reg_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8,
    parameter int IDXW  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push_valid,
    input  wire logic [WIDTH-1:0] i_push_value,
    input  wire logic [IDXW-1:0]  i_push_idx,
    output logic                  o_tail_valid,
    output logic [WIDTH-1:0]      o_tail_value,
    output logic [IDXW-1:0]       o_tail_idx
);

    logic             r_valid [DEPTH];
    logic [WIDTH-1:0] r_value [DEPTH];
    logic [IDXW-1:0]  r_idx   [DEPTH];

    logic             w_valid_in [DEPTH];
    logic [WIDTH-1:0] w_value_in [DEPTH];
    logic [IDXW-1:0]  w_idx_in   [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_valid_in[g] = i_push_valid;
            assign w_value_in[g] = i_push_value;
            assign w_idx_in[g]   = i_push_idx;
        end else begin : g_body
            assign w_valid_in[g] = r_valid[g-1];
            assign w_value_in[g] = r_value[g-1];
            assign w_idx_in[g]   = r_idx[g-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_value[i] <= '0;
                r_idx[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= w_valid_in[i];
                r_value[i] <= w_value_in[i];
                r_idx[i]   <= w_idx_in[i];
            end
        end
    end

    assign o_tail_valid = r_valid[DEPTH-1];
    assign o_tail_value = r_value[DEPTH-1];
    assign o_tail_idx   = r_idx[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/reg_stim_checker.sv
// =============================================================================
// Module      : reg_stim_checker
// Description : Drives a fixed vector sequence into a register DUT and checks
//               its response against a LATENCY-delayed expected copy.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module reg_stim_checker
    import reg_test_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1,
    parameter int HOLD    = 2,
    parameter int ERRW    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    reg_stim_checker_if.master bus
);

    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int DCW = $clog2(LATENCY_MAX) + 1;

    localparam logic [HCW-1:0]  c_HOLD_LAST  = HCW'(HOLD - 1);
    localparam logic [DCW-1:0]  c_DRAIN_LAST = DCW'(LATENCY - 1);
    localparam logic [IDXW-1:0] c_VEC_LAST   = IDXW'(NUM_VEC - 1);

    reg_chk_state_t  r_state,     w_state_nxt;
    logic [IDXW-1:0] r_vec_idx,   w_vec_idx_nxt;
    logic [HCW-1:0]  r_hold_cnt,  w_hold_cnt_nxt;
    logic [DCW-1:0]  r_drain_cnt, w_drain_cnt_nxt;
    logic [WIDTH-1:0] r_stim,     w_stim_nxt;
    logic            r_busy,      w_busy_nxt;
    logic            r_done,      w_done_nxt;
    logic            r_pass,      w_pass_nxt;
    logic [ERRW-1:0] r_err_count, w_err_count_nxt;
    logic [IDXW-1:0] r_ffi,       w_ffi_nxt;

    logic             w_tail_valid;
    logic [WIDTH-1:0] w_tail_value;
    logic [IDXW-1:0]  w_tail_idx;
    logic             w_mismatch;
    logic [IDXW-1:0]  w_vec_inc;

    function automatic logic [WIDTH-1:0] vec_at(input logic [IDXW-1:0] idx);
        return WIDTH'(REG_TEST_VEC[idx]);
    endfunction

    // Only DRIVE cycles carry an expected value down the line
    reg_delay_line #(
        .DEPTH (LATENCY),
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_delay_line (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (r_state == S_DRIVE),
        .i_push_value (r_stim),
        .i_push_idx   (r_vec_idx),
        .o_tail_valid (w_tail_valid),
        .o_tail_value (w_tail_value),
        .o_tail_idx   (w_tail_idx)
    );

    assign w_mismatch = w_tail_valid && (bus.resp != w_tail_value);
    assign w_vec_inc  = r_vec_idx + IDXW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_vec_idx_nxt   = r_vec_idx;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_stim_nxt      = r_stim;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = r_pass;
        w_err_count_nxt = r_err_count;
        w_ffi_nxt       = r_ffi;

        // err_count never returns to zero within a run, so zero means "no earlier mismatch"
        if (w_mismatch) begin
            if (r_err_count != '1)
                w_err_count_nxt = r_err_count + ERRW'(1);
            if (r_err_count == '0)
                w_ffi_nxt = w_tail_idx;
        end

        case (r_state)
            S_IDLE: begin
                w_stim_nxt = '0;
                w_busy_nxt = 1'b0;
                if (bus.start) begin
                    w_state_nxt     = S_DRIVE;
                    w_vec_idx_nxt   = '0;
                    w_hold_cnt_nxt  = '0;
                    w_stim_nxt      = vec_at('0);
                    w_busy_nxt      = 1'b1;
                    w_err_count_nxt = '0;
                    w_pass_nxt      = 1'b0;
                    w_ffi_nxt       = '0;
                end
            end
            S_DRIVE: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_hold_cnt_nxt = '0;
                    if (r_vec_idx == c_VEC_LAST) begin
                        w_state_nxt     = S_DRAIN;
                        w_drain_cnt_nxt = '0;
                        w_stim_nxt      = '0;
                    end else begin
                        w_vec_idx_nxt = w_vec_inc;
                        w_stim_nxt    = vec_at(w_vec_inc);
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HCW'(1);
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    // The final compare happens on this very edge
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (r_err_count == '0) && !w_mismatch;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + DCW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_stim_nxt  = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vec_idx   <= '0;
            r_hold_cnt  <= '0;
            r_drain_cnt <= '0;
            r_stim      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_ffi       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_vec_idx   <= w_vec_idx_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_stim      <= w_stim_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err_count <= w_err_count_nxt;
            r_ffi       <= w_ffi_nxt;
        end
    end

    assign bus.stim           = r_stim;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_count      = r_err_count;
    assign bus.first_fail_idx = r_ffi;

endmodule

`default_nettype wire

// File: tb/tb_reg_stim_checker.sv
// =============================================================================
// Module      : tb_reg_stim_checker
// Description : Directed, table-driven bench for reg_stim_checker.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_reg_stim_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] r_mask = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    reg_stim_checker_if #(.WIDTH(8), .ERRW(8)) if0 ();
    reg_stim_checker_if #(.WIDTH(8), .ERRW(8)) if3 ();
    reg_stim_checker_if #(.WIDTH(8), .ERRW(8)) if2 ();
    reg_stim_checker_if #(.WIDTH(8), .ERRW(2)) ifs ();

    reg_stim_checker #(.WIDTH(8), .LATENCY(1), .HOLD(2), .ERRW(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master));
    reg_stim_checker #(.WIDTH(8), .LATENCY(3), .HOLD(2), .ERRW(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.master));
    reg_stim_checker #(.WIDTH(8), .LATENCY(2), .HOLD(2), .ERRW(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.master));
    reg_stim_checker #(.WIDTH(8), .LATENCY(1), .HOLD(2), .ERRW(2)) u_duts (
        .clk(clk), .rst_n(rst_n), .bus(ifs.master));

    // Register DUT models: 1 flop with maskable stuck-at-0 bits, 3-flop chains, and a stuck-high bus
    logic [7:0] r_q0;
    logic [7:0] r_q3 [3];
    logic [7:0] r_q2 [3];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0 <= '0;
            for (int i = 0; i < 3; i++) begin
                r_q3[i] <= '0;
                r_q2[i] <= '0;
            end
        end else begin
            r_q0    <= if0.stim;
            r_q3[0] <= if3.stim; r_q3[1] <= r_q3[0]; r_q3[2] <= r_q3[1];
            r_q2[0] <= if2.stim; r_q2[1] <= r_q2[0]; r_q2[2] <= r_q2[1];
        end
    end
    assign if0.resp = r_q0 & ~r_mask;
    assign if3.resp = r_q3[2];
    assign if2.resp = r_q2[2];
    assign ifs.resp = 8'hFF;

    typedef struct {
        logic       start;
        logic [7:0] mask;
        logic [7:0] stim;
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] err;
        logic [1:0] ffi;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One run = 11 observed cycles after the start edge; errs holds a nibble per cycle
    task automatic add_run(input logic [7:0] mask, input logic [43:0] errs,
                           input logic [1:0] ffi_f, input logic pass_f);
        logic [87:0] sseq;
        vec_t        v;
        sseq = 88'h05050A0A03030000000000;
        for (int i = 0; i < 11; i++) begin
            v.start = (i == 0);
            v.mask  = mask;
            v.stim  = sseq[(10-i)*8 +: 8];
            v.busy  = (i <= 8);
            v.done  = (i == 9);
            v.pass  = (i >= 9) ? pass_f : 1'b0;
            v.err   = {4'h0, errs[(10-i)*4 +: 4]};
            v.ffi   = (v.err != 8'h00) ? ffi_f : 2'd0;
            tbl.push_back(v);
        end
    endtask

    task automatic wait_main_done(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (if0.done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " stim"}, 32'(if0.stim), 32'h0);
        chk({nm, " busy"}, 32'(if0.busy), 32'h0);
        chk({nm, " done"}, 32'(if0.done), 32'h0);
        chk({nm, " pass"}, 32'(if0.pass), 32'h0);
        chk({nm, " err"},  32'(if0.err_count), 32'h0);
        chk({nm, " ffi"},  32'(if0.first_fail_idx), 32'h0);
    endtask

    initial begin
        bit seen;
        int cnt3, cnt2, nd;
        bit d3, d2;

        if0.start = 1'b0; if3.start = 1'b0; if2.start = 1'b0; ifs.start = 1'b0;

        add_run(8'h00, 44'h00000000000, 2'd0, 1'b1);
        add_run(8'h01, 44'h00122234444, 2'd0, 1'b0);
        add_run(8'h02, 44'h00001234444, 2'd1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            if0.start = tbl[i].start;
            r_mask    = tbl[i].mask;
            @(posedge clk); #1;
            if0.start = 1'b0;
            chk($sformatf("row%0d stim", i), 32'(if0.stim), 32'(tbl[i].stim));
            chk($sformatf("row%0d busy", i), 32'(if0.busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d done", i), 32'(if0.done), 32'(tbl[i].done));
            chk($sformatf("row%0d pass", i), 32'(if0.pass), 32'(tbl[i].pass));
            chk($sformatf("row%0d err",  i), 32'(if0.err_count), 32'(tbl[i].err));
            chk($sformatf("row%0d ffi",  i), 32'(if0.first_fail_idx), 32'(tbl[i].ffi));
        end
        r_mask = 8'h00;

        // Latency sweep: 3-flop DUT against LATENCY 3 and LATENCY 2 checkers
        if3.start = 1'b1; if2.start = 1'b1;
        cnt3 = 0; cnt2 = 0; d3 = 0; d2 = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if3.start = 1'b0; if2.start = 1'b0;
            if (if3.busy) cnt3++;
            if (if2.busy) cnt2++;
            if (if3.done) d3 = 1'b1;
            if (if2.done) d2 = 1'b1;
        end
        chk("lat3 done seen", 32'(d3), 32'h1);
        chk("lat3 busy cycles", 32'(cnt3), 32'd11);
        chk("lat3 pass", 32'(if3.pass), 32'h1);
        chk("lat3 err", 32'(if3.err_count), 32'h0);
        chk("lat2 done seen", 32'(d2), 32'h1);
        chk("lat2 busy cycles", 32'(cnt2), 32'd10);
        chk("lat2 pass", 32'(if2.pass), 32'h0);

        // Saturation with a 2-bit counter: eight mismatches must stop at 3
        ifs.start = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            ifs.start = 1'b0;
            if (ifs.done) seen = 1'b1;
        end
        chk("sat done seen", 32'(seen), 32'h1);
        chk("sat err", 32'(ifs.err_count), 32'h3);
        chk("sat pass", 32'(ifs.pass), 32'h0);

        // start held high: one done per run, restart only once back in IDLE
        if0.start = 1'b1;
        nd = 0;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            if (if0.done) nd++;
        end
        chk("held start done count", 32'(nd), 32'd1);
        chk("held start busy after DONE", 32'(if0.busy), 32'h0);
        @(posedge clk); #1;
        chk("held start restart busy", 32'(if0.busy), 32'h1);
        if0.start = 1'b0;
        wait_main_done(seen);
        chk("held start second done", 32'(seen), 32'h1);
        chk("held start second pass", 32'(if0.pass), 32'h1);
        @(posedge clk); #1;

        // Reset during DRIVE cycle 5
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset stim", 32'(if0.stim), 32'h03);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (if0.done || if0.busy) nd++;
        end
        chk("post-reset no done/busy", 32'(nd), 32'd0);

        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        wait_main_done(seen);
        chk("post-reset done", 32'(seen), 32'h1);
        chk("post-reset pass", 32'(if0.pass), 32'h1);
        chk("post-reset err", 32'(if0.err_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
